// File: rtl/shake_pad_loader.sv
// rtl/shake_pad_loader.sv - packs a 64-bit word stream into SHAKE256 rate blocks and pads the last one.
// Define PAD_DOMAIN_SEL_EN to add the sha3_mode input (domain byte 0x06 instead of 0x1F).
module shake_pad_loader #(
  parameter int RATE_LANES = 17,
  parameter int MAX_BLOCKS = 7,
  parameter int ADDR_W     = 3
) (
  input  logic                       clock,
  input  logic                       reset,
`ifdef PAD_DOMAIN_SEL_EN
  input  logic                       sha3_mode,
`endif
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [63:0]                in_data,
  input  logic                       in_last,
  input  logic [3:0]                 in_bytes,
  output logic [64*RATE_LANES-1:0]   blk_data,
  output logic [ADDR_W-1:0]          blk_addr,
  output logic                       blk_wren,
  output logic [ADDR_W-1:0]          blk_count,
  output logic [10:0]                last_len,
  output logic                       done,
  output logic                       overflow
);

  localparam int RATE_BYTES = RATE_LANES * 8;
  localparam int BUF_W      = RATE_BYTES * 8;
  localparam int LANE_W     = $clog2(RATE_LANES + 1);
  localparam int POS_W      = $clog2(RATE_BYTES + 1);

  typedef enum logic [2:0] {
    FILL,
    PAD,
    WRITE_FULL,
    WRITE_PAD,
    DONE,
    ERR
  } state_t;

  state_t             state;
  logic [BUF_W-1:0]   buffer;
  logic [BUF_W-1:0]   pad_buffer;
  logic [LANE_W-1:0]  lane_idx;
  logic [POS_W-1:0]   pos;
  logic [POS_W-1:0]   last_pos;
  logic               pad_pending;
  logic [3:0]         bytes_eff;
  logic [63:0]        in_word;
  logic [7:0]         domain;
  logic               at_limit;

`ifdef PAD_DOMAIN_SEL_EN
  assign domain = sha3_mode ? 8'h06 : 8'h1F;
`else
  assign domain = 8'h1F;
`endif

  assign blk_data  = buffer;
  assign at_limit  = (blk_count == ADDR_W'(MAX_BLOCKS));
  assign bytes_eff = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
  assign last_pos  = POS_W'({lane_idx, 3'b000}) + POS_W'(bytes_eff);

  // Bytes past in_bytes in the final word are forced to zero before they land in the buffer.
  always_comb begin
    in_word = '0;
    for (int j = 0; j < 8; j++) begin
      if (!in_last || (4'(j) < bytes_eff))
        in_word[8*j +: 8] = in_data[8*j +: 8];
    end
  end

  // Domain byte at pos, final 0x80 at the top byte; both land on one byte when pos is the last one.
  always_comb begin
    pad_buffer = buffer;
    for (int k = 0; k < RATE_BYTES; k++) begin
      if (pos == POS_W'(k))
        pad_buffer[8*k +: 8] = buffer[8*k +: 8] ^ domain;
    end
    pad_buffer[BUF_W-1 -: 8] = pad_buffer[BUF_W-1 -: 8] ^ 8'h80;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= FILL;
      buffer      <= '0;
      lane_idx    <= '0;
      pos         <= '0;
      pad_pending <= 1'b0;
      blk_addr    <= '0;
      blk_count   <= '0;
      last_len    <= '0;
      in_ready    <= 1'b1;
      blk_wren    <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      blk_wren <= 1'b0;
      case (state)
        FILL: begin
          if (in_valid && in_ready) begin
            for (int i = 0; i < RATE_LANES; i++) begin
              if (lane_idx == LANE_W'(i))
                buffer[64*i +: 64] <= in_word;
            end
            lane_idx <= lane_idx + 1'b1;
            if (in_last && (last_pos != POS_W'(RATE_BYTES))) begin
              pos      <= last_pos;
              state    <= PAD;
              in_ready <= 1'b0;
            end else if (in_last || (lane_idx == LANE_W'(RATE_LANES - 1))) begin
              // A message ending exactly on a block boundary still needs a pad-only block.
              pad_pending <= in_last;
              pos         <= '0;
              in_ready    <= 1'b0;
              if (at_limit) begin
                state    <= ERR;
                overflow <= 1'b1;
              end else begin
                state    <= WRITE_FULL;
                blk_wren <= 1'b1;
                blk_addr <= blk_count;
              end
            end
          end
        end
        PAD: begin
          buffer      <= pad_buffer;
          last_len    <= 11'({pos, 3'b000});
          pad_pending <= 1'b0;
          if (at_limit) begin
            state    <= ERR;
            overflow <= 1'b1;
          end else begin
            state    <= WRITE_PAD;
            blk_wren <= 1'b1;
            blk_addr <= blk_count;
          end
        end
        WRITE_FULL: begin
          blk_count <= blk_count + 1'b1;
          buffer    <= '0;
          lane_idx  <= '0;
          if (pad_pending) begin
            state <= PAD;
          end else begin
            state    <= FILL;
            in_ready <= 1'b1;
          end
        end
        WRITE_PAD: begin
          blk_count <= blk_count + 1'b1;
          buffer    <= '0;
          lane_idx  <= '0;
          state     <= DONE;
          done      <= 1'b1;
        end
        DONE: begin
          in_ready <= 1'b0;
        end
        ERR: begin
          in_ready <= 1'b0;
        end
        default: begin
          state    <= ERR;
          overflow <= 1'b1;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shake_pad_loader.sv
// tb/tb_shake_pad_loader.sv - scoreboard bench for shake_pad_loader.
// Expected blocks come from a byte-level padding model and are checked on every blk_wren.
module tb_shake_pad_loader;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_data = '0;
  logic          in_last = 1'b0;
  logic [3:0]    in_bytes = '0;
  logic [1087:0] blk_data;
  logic [2:0]    blk_addr;
  logic          blk_wren;
  logic [2:0]    blk_count;
  logic [10:0]   last_len;
  logic          done;
  logic          overflow;

  typedef struct {
    logic [2:0]    addr;
    logic [1087:0] data;
  } blk_t;

  blk_t       exp_q[$];
  logic [7:0] msg[$];
  int         compared = 0;
  int         mismatched = 0;
  blk_t       mon_e;
  int         mon_bad;

  always #5 clock = ~clock;

  shake_pad_loader dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_data  (blk_data),
    .blk_addr  (blk_addr),
    .blk_wren  (blk_wren),
    .blk_count (blk_count),
    .last_len  (last_len),
    .done      (done),
    .overflow  (overflow)
  );

  always @(negedge clock) begin
    if (reset && blk_wren) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_write: got write at addr %0d, required none", blk_addr);
      end else begin
        mon_e = exp_q.pop_front();
        mon_bad = -1;
        for (int i = 0; i < 17; i++)
          if (mon_bad < 0 && blk_data[64*i +: 64] !== mon_e.data[64*i +: 64]) mon_bad = i;
        if (blk_addr !== mon_e.addr || mon_bad >= 0) begin
          mismatched++;
          if (mon_bad < 0) mon_bad = 0;
          $display("FAIL block_write: addr got %0d required %0d; lane %0d got %h required %h",
                   blk_addr, mon_e.addr, mon_bad, blk_data[64*mon_bad +: 64], mon_e.data[64*mon_bad +: 64]);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_bytes = '0; in_data = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic push_expected();
    int   len = msg.size();
    int   nblk = len / 136 + 1;
    int   r = len % 136;
    blk_t b;
    for (int blk = 0; blk < nblk && blk < 7; blk++) begin
      b.addr = 3'(blk);
      b.data = '0;
      for (int k = 0; k < 136; k++)
        if (blk * 136 + k < len) b.data[8*k +: 8] = msg[blk * 136 + k];
      if (blk == nblk - 1) begin
        b.data[8*r +: 8]   = b.data[8*r +: 8] ^ 8'h1F;
        b.data[1087 -: 8]  = b.data[1087 -: 8] ^ 8'h80;
      end
      exp_q.push_back(b);
    end
  endtask

  // Drives the whole message; unused bytes of the last word carry 0xFF so masking is exercised.
  task automatic send_msg(input int hold);
    int len = msg.size();
    int nw = (len == 0) ? 1 : (len + 7) / 8;
    int t;
    for (int w = 0; w < nw; w++) begin
      for (int j = 0; j < 8; j++)
        in_data[8*j +: 8] = (8*w + j < len) ? msg[8*w + j] : 8'hFF;
      in_last  = (w == nw - 1);
      in_bytes = (w == nw - 1) ? 4'(len - 8*w) : 4'd5;
      in_valid = 1'b1;
      t = 0;
      @(negedge clock);
      while (!in_ready && t < 50) begin
        @(negedge clock);
        t++;
      end
      if (!in_ready) begin
        compared++; mismatched++;
        $display("FAIL accept_timeout: word %0d not accepted, in_ready got %b required 1", w, in_ready);
        in_valid = 1'b0;
        return;
      end
      @(posedge clock); #1;
    end
    if (hold > 0) begin
      in_last = 1'b0;
      in_data = '1;
      repeat (hold) @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_end();
    int t = 0;
    @(negedge clock);
    while (!done && !overflow && t < 200) begin
      @(negedge clock);
      t++;
    end
  endtask

  task automatic check_msg(input string name, input int hold);
    int len = msg.size();
    int nblk = len / 136 + 1;
    int exp_len = (len % 136) * 8;
    do_reset();
    push_expected();
    send_msg(hold);
    wait_end();
    compared++;
    if (done !== 1'b1) begin
      mismatched++; $display("FAIL %s_done: got %b required 1", name, done);
    end
    compared++;
    if (blk_count !== 3'(nblk)) begin
      mismatched++; $display("FAIL %s_blk_count: got %0d required %0d", name, blk_count, nblk);
    end
    compared++;
    if (last_len !== 11'(exp_len)) begin
      mismatched++; $display("FAIL %s_last_len: got %0d required %0d", name, last_len, exp_len);
    end
    compared++;
    if (overflow !== 1'b0 || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_flags: overflow/in_ready got %b/%b required 0/0", name, overflow, in_ready);
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++; $display("FAIL %s_writes_missing: got %0d pending required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic fill_random(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    compared++;
    if (in_ready !== 1'b1 || blk_wren !== 1'b0) begin
      mismatched++; $display("FAIL reset_ready_wren: got %b/%b required 1/0", in_ready, blk_wren);
    end
    compared++;
    if (done !== 1'b0 || overflow !== 1'b0) begin
      mismatched++; $display("FAIL reset_done_overflow: got %b/%b required 0/0", done, overflow);
    end
    compared++;
    if (blk_count !== 3'd0 || blk_addr !== 3'd0 || last_len !== 11'd0) begin
      mismatched++;
      $display("FAIL reset_counters: count/addr/len got %0d/%0d/%0d required 0/0/0", blk_count, blk_addr, last_len);
    end
  endtask

  task automatic test_empty();
    msg.delete();
    check_msg("empty", 0);
  endtask

  task automatic test_masking();
    msg.delete();
    msg.push_back(8'hCC); msg.push_back(8'hBB); msg.push_back(8'hAA);
    check_msg("mask3", 0);
  endtask

  task automatic test_boundaries();
    fill_random(135); check_msg("len135", 0);
    fill_random(136); check_msg("len136", 0);
    fill_random(8);   check_msg("len8", 0);
    fill_random(272); check_msg("len272", 0);
  endtask

  task automatic test_back_to_back();
    fill_random(20);  check_msg("hold20", 6);
    fill_random(300); check_msg("hold300", 8);
    fill_random(136); check_msg("hold136", 8);
  endtask

  task automatic test_overflow();
    fill_random(7 * 136 + 1);
    do_reset();
    push_expected();
    send_msg(0);
    wait_end();
    repeat (5) @(negedge clock);
    compared++;
    if (overflow !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL ovf_flags: overflow/done/in_ready got %b/%b/%b required 1/0/0", overflow, done, in_ready);
    end
    compared++;
    if (blk_count !== 3'd7) begin
      mismatched++; $display("FAIL ovf_blk_count: got %0d required 7", blk_count);
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++; $display("FAIL ovf_writes_missing: got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
    do_reset();
    @(negedge clock);
    compared++;
    if (overflow !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1 || blk_count !== 3'd0) begin
      mismatched++;
      $display("FAIL ovf_reset: overflow/done/in_ready/count got %b/%b/%b/%0d required 0/0/1/0",
               overflow, done, in_ready, blk_count);
    end
  endtask

  task automatic test_reset_mid_fill();
    do_reset();
    for (int w = 0; w < 5; w++) begin
      in_data = {$urandom, $urandom};
      in_last = 1'b0;
      in_valid = 1'b1;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    do_reset();
    @(negedge clock);
    compared++;
    if (blk_count !== 3'd0 || in_ready !== 1'b1 || blk_wren !== 1'b0) begin
      mismatched++;
      $display("FAIL midfill_reset: count/in_ready/wren got %0d/%b/%b required 0/1/0", blk_count, in_ready, blk_wren);
    end
    msg.delete();
    check_msg("after_midfill", 0);
  endtask

  initial begin
    test_reset();
    test_empty();
    test_masking();
    test_boundaries();
    test_back_to_back();
    test_overflow();
    test_reset_mid_fill();
    repeat (3) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
